// File: rtl/sc_level_comparator.sv
// -----------------------------------------------------------------------------
// sc_level_comparator
//
// Game-progress responder for the Frogger general state machine. It watches
// the frog row and the car-collision flag, keeps the level and lives counters,
// and raises one of four events:
//   levelUp - the frog reached the goal row (held until acknowledged)
//   death   - the frog was hit and lives remain (held until acknowledged)
//   win     - the goal was reached on the last level (sticky)
//   lose    - the last life was lost (sticky)
//
// The general FSM consumes these events and answers with ack. A win or lose is
// left only through clear or reset. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module sc_level_comparator #(
    parameter int ROW_WIDTH   = 3,  // width of the frog row bus
    parameter int GOAL_ROW    = 0,  // row index that completes a level
    parameter int LEVEL_WIDTH = 2,  // width of the level counter
    parameter int MAX_LEVEL   = 3,  // last level; goal reached here is a win
    parameter int LIVES_WIDTH = 2,  // width of the lives counter
    parameter int LIVES_INIT  = 3   // lives after reset or clear, at least 1
) (
    input  logic                   SC_LEVELCOMPARATOR_CLOCK_50,
    input  logic                   SC_LEVELCOMPARATOR_RESET_InLow,
    input  logic                   SC_LEVELCOMPARATOR_clear_InLow,
    input  logic [ROW_WIDTH-1:0]   SC_LEVELCOMPARATOR_frogRow_InBUS,
    input  logic                   SC_LEVELCOMPARATOR_collision_InHigh,
    input  logic                   SC_LEVELCOMPARATOR_ack_InHigh,
    output logic                   SC_LEVELCOMPARATOR_levelUp_OutHigh,
    output logic                   SC_LEVELCOMPARATOR_death_OutHigh,
    output logic                   SC_LEVELCOMPARATOR_win_OutHigh,
    output logic                   SC_LEVELCOMPARATOR_lose_OutHigh,
    output logic [LEVEL_WIDTH-1:0] SC_LEVELCOMPARATOR_level_OutBUS,
    output logic [LIVES_WIDTH-1:0] SC_LEVELCOMPARATOR_lives_OutBUS
);

    // -------------------------------------------------------------------------
    // Constants sized to the buses they are compared against
    // -------------------------------------------------------------------------
    localparam logic [ROW_WIDTH-1:0]   GOAL_ROW_C   = ROW_WIDTH'(GOAL_ROW);
    localparam logic [LEVEL_WIDTH-1:0] MAX_LEVEL_C  = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE_C  = LEVEL_WIDTH'(1);
    localparam logic [LIVES_WIDTH-1:0] LIVES_INIT_C = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LIVES_WIDTH-1:0] LIVES_ONE_C  = LIVES_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Game state
    //   RUN        - waiting for a collision or a fresh goal arrival
    //   LEVEL_REQ  - level-up requested, waiting for ack
    //   DEATH_REQ  - life lost, waiting for ack
    //   WIN / LOSE - terminal until clear or reset
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        RUN       = 3'd0,
        LEVEL_REQ = 3'd1,
        DEATH_REQ = 3'd2,
        WIN       = 3'd3,
        LOSE      = 3'd4
    } state_e;

    state_e                 state_q,  state_d;
    logic [LEVEL_WIDTH-1:0] level_q,  level_d;
    logic [LIVES_WIDTH-1:0] lives_q,  lives_d;
    logic                   at_goal_prev_q;

    // Registered event flags, decoded from the next state so each output is a flop.
    logic                   level_up_q;
    logic                   death_q;
    logic                   win_q;
    logic                   lose_q;

    // Reset and clear do the same thing; reset is listed first only for clarity.
    logic                   init_req;
    logic                   at_goal;
    logic                   goal_hit;

    assign init_req = ~SC_LEVELCOMPARATOR_RESET_InLow | ~SC_LEVELCOMPARATOR_clear_InLow;

    // The frog counts as arriving only on the cycle it enters the goal row, so
    // sitting on the goal (including across reset or clear) never re-fires.
    assign at_goal  = (SC_LEVELCOMPARATOR_frogRow_InBUS == GOAL_ROW_C);
    assign goal_hit = at_goal & ~at_goal_prev_q;

    // Next-state and counter update logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;

        unique case (state_q)
            RUN: begin
                // A collision wins over a goal arrival in the same cycle.
                if (SC_LEVELCOMPARATOR_collision_InHigh) begin
                    if (lives_q <= LIVES_ONE_C) begin
                        // Last life gone; the guard on <= keeps lives from
                        // wrapping even if the counter were already at zero.
                        lives_d = '0;
                        state_d = LOSE;
                    end else begin
                        lives_d = lives_q - LIVES_ONE_C;
                        state_d = DEATH_REQ;
                    end
                end else if (goal_hit) begin
                    if (level_q >= MAX_LEVEL_C) begin
                        // Final level finished: the level saturates and the game is won.
                        state_d = WIN;
                    end else begin
                        level_d = level_q + LEVEL_ONE_C;
                        state_d = LEVEL_REQ;
                    end
                end
            end

            LEVEL_REQ, DEATH_REQ: begin
                // Hold the request, ignore play, release on ack.
                if (SC_LEVELCOMPARATOR_ack_InHigh) begin
                    state_d = RUN;
                end
            end

            WIN, LOSE: begin
                // Terminal: only clear or reset leaves these states.
                state_d = state_q;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, counters and the goal-edge history register.
    always_ff @(posedge SC_LEVELCOMPARATOR_CLOCK_50) begin
        // NOTE: the reset is synchronous, so it lives inside the clocked block
        // and not in the sensitivity list; every assignment here is
        // non-blocking so all flops update together from pre-edge values.
        if (init_req) begin
            state_q        <= RUN;
            level_q        <= '0;
            lives_q        <= LIVES_INIT_C;
            at_goal_prev_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            lives_q        <= lives_d;
            at_goal_prev_q <= at_goal;
        end
    end

    // Event output flops, one-hot by construction because they decode a single next state.
    always_ff @(posedge SC_LEVELCOMPARATOR_CLOCK_50) begin
        if (init_req) begin
            level_up_q <= 1'b0;
            death_q    <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            level_up_q <= (state_d == LEVEL_REQ);
            death_q    <= (state_d == DEATH_REQ);
            win_q      <= (state_d == WIN);
            lose_q     <= (state_d == LOSE);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign SC_LEVELCOMPARATOR_levelUp_OutHigh = level_up_q;
    assign SC_LEVELCOMPARATOR_death_OutHigh   = death_q;
    assign SC_LEVELCOMPARATOR_win_OutHigh     = win_q;
    assign SC_LEVELCOMPARATOR_lose_OutHigh    = lose_q;
    assign SC_LEVELCOMPARATOR_level_OutBUS    = level_q;
    assign SC_LEVELCOMPARATOR_lives_OutBUS    = lives_q;

endmodule

// File: tb/tb_sc_level_comparator.sv
// -----------------------------------------------------------------------------
// tb_sc_level_comparator
//
// Directed bench for sc_level_comparator with the default parameters
// (8 rows, goal row 0, levels 0..3, three lives). Inputs change 1 ns after a
// rising edge, and outputs are checked at that same point, well clear of the
// next edge.
// -----------------------------------------------------------------------------
module tb_sc_level_comparator;

    logic       clk;
    logic       rst_n;
    logic       clr_n;
    logic [2:0] row;
    logic       coll;
    logic       ack;
    logic       level_up;
    logic       death;
    logic       win;
    logic       lose;
    logic [1:0] level;
    logic [1:0] lives;

    int checks   = 0;
    int failures = 0;

    sc_level_comparator dut (
        .SC_LEVELCOMPARATOR_CLOCK_50         (clk),
        .SC_LEVELCOMPARATOR_RESET_InLow      (rst_n),
        .SC_LEVELCOMPARATOR_clear_InLow      (clr_n),
        .SC_LEVELCOMPARATOR_frogRow_InBUS    (row),
        .SC_LEVELCOMPARATOR_collision_InHigh (coll),
        .SC_LEVELCOMPARATOR_ack_InHigh       (ack),
        .SC_LEVELCOMPARATOR_levelUp_OutHigh  (level_up),
        .SC_LEVELCOMPARATOR_death_OutHigh    (death),
        .SC_LEVELCOMPARATOR_win_OutHigh      (win),
        .SC_LEVELCOMPARATOR_lose_OutHigh     (lose),
        .SC_LEVELCOMPARATOR_level_OutBUS     (level),
        .SC_LEVELCOMPARATOR_lives_OutBUS     (lives)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One comparison: count it, then assert equality.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check every output against the expected values.
    task automatic check_all(input string tag, input logic lu, input logic de,
                             input logic wi, input logic lo,
                             input logic [1:0] lvl, input logic [1:0] liv);
        check({tag, ".levelUp"}, {31'd0, level_up}, {31'd0, lu});
        check({tag, ".death"},   {31'd0, death},    {31'd0, de});
        check({tag, ".win"},     {31'd0, win},      {31'd0, wi});
        check({tag, ".lose"},    {31'd0, lose},     {31'd0, lo});
        check({tag, ".level"},   {30'd0, level},    {30'd0, lvl});
        check({tag, ".lives"},   {30'd0, lives},    {30'd0, liv});
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_n = 1'b1;
        row   = 3'd5;
        coll  = 1'b0;
        ack   = 1'b0;
        step();
        step();
        check_all("reset", 0, 0, 0, 0, 2'd0, 2'd3);
        rst_n = 1'b1;

        // ---- 1: walk to the goal, hold the request, then acknowledge ----
        for (int r = 4; r >= 1; r--) begin
            row = 3'(r);
            step();
        end
        check_all("walk_no_goal", 0, 0, 0, 0, 2'd0, 2'd3);
        row = 3'd0;
        step();
        check_all("levelup_first", 1, 0, 0, 0, 2'd1, 2'd3);
        for (int i = 0; i < 10; i++) step();
        check_all("levelup_held", 1, 0, 0, 0, 2'd1, 2'd3);
        ack = 1'b1;
        step();
        check_all("levelup_acked", 0, 0, 0, 0, 2'd1, 2'd3);
        ack = 1'b0;
        // Still on the goal row after the ack: no new arrival.
        step();
        check_all("goal_sitting", 0, 0, 0, 0, 2'd1, 2'd3);

        // ---- 2: collision, second collision ignored while pending ----
        row  = 3'd3;
        coll = 1'b1;
        step();
        check_all("death_first", 0, 1, 0, 0, 2'd1, 2'd2);
        step();
        check_all("death_pending_coll", 0, 1, 0, 0, 2'd1, 2'd2);
        coll = 1'b0;
        ack  = 1'b1;
        step();
        check_all("death_acked", 0, 0, 0, 0, 2'd1, 2'd2);
        ack = 1'b0;

        // ---- 3: run out of lives, terminal lose, then clear ----
        coll = 1'b1;
        step();
        coll = 1'b0;
        check_all("death_second", 0, 1, 0, 0, 2'd1, 2'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_all("death_second_acked", 0, 0, 0, 0, 2'd1, 2'd1);
        coll = 1'b1;
        step();
        coll = 1'b0;
        check_all("lose_entered", 0, 0, 0, 1, 2'd1, 2'd0);
        ack  = 1'b1;
        coll = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_all("lose_frozen", 0, 0, 0, 1, 2'd1, 2'd0);
        ack   = 1'b0;
        coll  = 1'b0;
        clr_n = 1'b0;
        step();
        check_all("clear_after_lose", 0, 0, 0, 0, 2'd0, 2'd3);
        clr_n = 1'b1;

        // ---- 4: collision and goal arrival in the same cycle ----
        row = 3'd3;
        step();
        row  = 3'd0;
        coll = 1'b1;
        step();
        coll = 1'b0;
        check_all("coll_beats_goal", 0, 1, 0, 0, 2'd0, 2'd2);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_all("coll_goal_acked", 0, 0, 0, 0, 2'd0, 2'd2);
        step();
        check_all("coll_goal_no_late_lvl", 0, 0, 0, 0, 2'd0, 2'd2);

        // ---- 5: climb to the last level and win ----
        for (int l = 1; l <= 3; l++) begin
            row = 3'd1;
            step();
            row = 3'd0;
            step();
            check_all($sformatf("climb_%0d", l), 1, 0, 0, 0, 2'(l), 2'd2);
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        row = 3'd1;
        step();
        row = 3'd0;
        step();
        check_all("win_entered", 0, 0, 1, 0, 2'd3, 2'd2);
        for (int i = 0; i < 20; i++) begin
            ack  = (i % 3 == 0);
            row  = (i % 5 == 2) ? 3'd1 : 3'd0;
            step();
        end
        ack = 1'b0;
        row = 3'd0;
        step();
        check_all("win_frozen", 0, 0, 1, 0, 2'd3, 2'd2);
        coll = 1'b1;
        step();
        coll = 1'b0;
        check_all("win_ignores_coll", 0, 0, 1, 0, 2'd3, 2'd2);

        // ---- 6: reset aborts a pending level-up; frog held on goal ----
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        check_all("clear_after_win", 0, 0, 0, 0, 2'd0, 2'd3);
        row = 3'd1;
        step();
        row = 3'd0;
        step();
        check_all("pre_reset_levelup", 1, 0, 0, 0, 2'd1, 2'd3);
        rst_n = 1'b0;
        step();
        check_all("reset_aborts", 0, 0, 0, 0, 2'd0, 2'd3);
        rst_n = 1'b1;
        ack   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        ack = 1'b0;
        check_all("goal_through_reset", 0, 0, 0, 0, 2'd0, 2'd3);
        row = 3'd2;
        step();
        row = 3'd0;
        step();
        check_all("reenter_after_reset", 1, 0, 0, 0, 2'd1, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
